trigger_debounce: RTL

- Front-end conditioner for an asynchronous, bouncy trigger source (button, external comparator).
- Synchronises the raw input into the clk domain, then debounces it.
- Drives a clean, glitch-free level into the single-cycle trigger pulse generator directly downstream, whose trigger_in it feeds.
- Also reports aborted transitions (bounces) for diagnostics.

---
 rtl/trigger_debounce.sv | 121 ++++++++++++
 1 files changed

// File: rtl/trigger_debounce.sv
// trigger_debounce: synchronise and debounce an asynchronous trigger input.
//
// Turns a bouncy, asynchronous trigger source into a clean, glitch-free level
// for the single-cycle pulse generator downstream. Transitions that start but
// never settle are counted as bounces for diagnostics.
//
// Ports:
//   clk          in   sole clock, all logic on the rising edge
//   rst_n        in   synchronous active-low reset
//   raw_in       in   asynchronous raw trigger
//   level_out    out  debounced level (feeds downstream trigger_in)
//   busy         out  high while a candidate transition is being qualified
//   bounce_err   out  one-cycle pulse after a candidate transition is aborted
//   bounce_count out  saturating count of aborted transitions
module trigger_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_in,
    output logic       level_out,
    output logic       busy,
    output logic       bounce_err,
    output logic [7:0] bounce_count
);

    // Bit 1 is the debounced level and bit 0 marks a qualification in
    // progress, so both outputs come straight from the state register.
    localparam logic [1:0] STABLE_LOW  = 2'b00;
    localparam logic [1:0] CHECK_HIGH  = 2'b01;
    localparam logic [1:0] STABLE_HIGH = 2'b10;
    localparam logic [1:0] CHECK_LOW   = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam bit                   SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   bounce_err_q, bounce_err_d;
    logic [7:0]             bounce_count_q, bounce_count_d;
    logic                   s;
    logic                   abort;

    // Plain shift chain; nothing may sit between the synchroniser stages.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = SINGLE ? STABLE_HIGH : CHECK_HIGH;
                    cnt_d   = SINGLE ? '0 : CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = SINGLE ? STABLE_LOW : CHECK_LOW;
                    cnt_d   = SINGLE ? '0 : CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign bounce_err_d   = abort;
    assign bounce_count_d = (abort && bounce_count_q != 8'hFF) ? bounce_count_q + 8'd1
                                                                : bounce_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q         <= '0;
            state_q        <= STABLE_LOW;
            cnt_q          <= '0;
            bounce_err_q   <= 1'b0;
            bounce_count_q <= '0;
        end else begin
            sync_q         <= sync_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bounce_err_q   <= bounce_err_d;
            bounce_count_q <= bounce_count_d;
        end
    end

    assign level_out    = state_q[1];
    assign busy         = state_q[0];
    assign bounce_err   = bounce_err_q;
    assign bounce_count = bounce_count_q;

endmodule
